// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the data memory.
// The master side issues requests and consumes responses; the slave side is the memory.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory answering one load/store at a time with byte/half/word access.
// Latency: response valid LATENCY+1 edges after acceptance (acceptance edge counted as the first).
// Backpressure: response held stable until rsp_ready; no new request accepted until back in IDLE.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT4  = 4'(LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        l_we, l_uns;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_size;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero latency the access happens on the acceptance edge itself, so the
    // live request fields are used in IDLE and the latched copy afterwards.
    logic        acc_we, acc_uns;
    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  acc_size;
    always_comb begin
        acc_we    = l_we;
        acc_uns   = l_uns;
        acc_addr  = l_addr;
        acc_wdata = l_wdata;
        acc_size  = l_size;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_uns   = bus.req_unsigned;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_size  = bus.req_size;
        end
    end

    logic          enter_resp;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [4:0]    bsh;
    logic [4:0]    hsh;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;

    assign enter_resp = ((state == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd1));
    assign idx     = acc_addr[AW+1:2];
    assign bsh     = {acc_addr[1:0], 3'b000};
    assign hsh     = {acc_addr[1], 4'b0000};
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[bsh +: 8];
    assign rd_half = rd_word[hsh +: 16];

    always_comb begin
        acc_err = (acc_addr >= LIMIT);
        unique case (acc_size)
            2'b00:   acc_err = acc_err;
            2'b01:   acc_err = acc_err | acc_addr[0];
            2'b10:   acc_err = acc_err | (acc_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_data = rd_word;
        case (acc_size)
            2'b00:   ld_data = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_data = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // Array is deliberately left out of reset; a store only lands on the edge into RESP,
    // so a reset during WAIT (state forced to IDLE) can never commit it.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            case (acc_size)
                2'b00:   mem[idx][bsh +: 8]  <= acc_wdata[7:0];
                2'b01:   mem[idx][hsh +: 16] <= acc_wdata[15:0];
                default: mem[idx]            <= acc_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            l_we    <= 1'b0;
            l_uns   <= 1'b0;
            l_addr  <= 32'h0;
            l_wdata <= 32'h0;
            l_size  <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_we || acc_err) ? 32'h0 : ld_data;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        l_we    <= bus.req_we;
                        l_uns   <= bus.req_unsigned;
                        l_addr  <= bus.req_addr;
                        l_wdata <= bus.req_wdata;
                        l_size  <= bus.req_size;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT4;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, a byte-array memory model
// with per-cycle handshake/latency/data checks, plus directed transactions with literal results.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    dmem_responder_if i0 ();
    dmem_responder_if i1 ();

    assign i0.req_valid    = req_valid && (sel == 0);
    assign i1.req_valid    = req_valid && (sel == 1);
    assign i0.rsp_ready    = rsp_ready && (sel == 0);
    assign i1.rsp_ready    = rsp_ready && (sel == 1);
    assign i0.req_we       = req_we;
    assign i1.req_we       = req_we;
    assign i0.req_addr     = req_addr;
    assign i1.req_addr     = req_addr;
    assign i0.req_wdata    = req_wdata;
    assign i1.req_wdata    = req_wdata;
    assign i0.req_size     = req_size;
    assign i1.req_size     = req_size;
    assign i0.req_unsigned = req_unsigned;
    assign i1.req_unsigned = req_unsigned;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    logic        d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_rsp_rdata;
    assign d_req_ready = (sel == 1) ? i1.req_ready : i0.req_ready;
    assign d_rsp_valid = (sel == 1) ? i1.rsp_valid : i0.rsp_valid;
    assign d_rsp_err   = (sel == 1) ? i1.rsp_err   : i0.rsp_err;
    assign d_rsp_rdata = (sel == 1) ? i1.rsp_rdata : i0.rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: one byte array per instance, updated when the store's response appears.
    logic [7:0]  mm [2][1024];
    logic        outst, seen;
    int          acc_edge;
    logic [31:0] exp_d, held_d;
    logic        exp_e, held_e;
    logic        pend_we;
    int          pend_a, pend_n;
    logic [31:0] pend_wd;

    always @(negedge clk) begin
        if (!rst) begin
            outst = 1'b0;
            seen  = 1'b0;
        end else begin
            chk1("req_ready_vs_model", d_req_ready, !outst);
            if (d_rsp_valid) begin
                chk1("rsp_valid_only_when_outstanding", outst, 1'b1);
                if (outst && !seen) begin
                    seen = 1'b1;
                    chk32("latency_edges", 32'(cyc - acc_edge + 1), (sel == 1) ? 32'd1 : 32'd3);
                    chk32("model_rdata", d_rsp_rdata, exp_d);
                    chk1("model_err", d_rsp_err, exp_e);
                    held_d = d_rsp_rdata;
                    held_e = d_rsp_err;
                    if (pend_we)
                        for (int k = 0; k < pend_n; k++) mm[sel][pend_a + k] = pend_wd[8*k +: 8];
                end else if (seen) begin
                    chk32("rdata_stable", d_rsp_rdata, held_d);
                    chk1("err_stable", d_rsp_err, held_e);
                end
                if (rsp_ready) begin
                    outst = 1'b0;
                    seen  = 1'b0;
                end
            end
            if (req_valid && d_req_ready) begin
                int a;
                logic [7:0] b;
                logic [15:0] h;
                a = int'(req_addr[9:0]);
                outst    = 1'b1;
                seen     = 1'b0;
                acc_edge = cyc + 1;
                pend_we  = 1'b0;
                exp_d    = 32'h0;
                exp_e    = (req_size == 2'd3) || (req_size == 2'd1 && req_addr % 2 != 0) ||
                           (req_size == 2'd2 && req_addr % 4 != 0) || (req_addr >= 32'd1024);
                if (!exp_e && req_we) begin
                    pend_we = 1'b1;
                    pend_a  = a;
                    pend_n  = 1 << req_size;
                    pend_wd = req_wdata;
                end else if (!exp_e) begin
                    b = mm[sel][a];
                    h = {mm[sel][a+1], mm[sel][a]};
                    if (req_size == 2'd0)
                        exp_d = req_unsigned ? 32'(b) : 32'(signed'(b));
                    else if (req_size == 2'd1)
                        exp_d = req_unsigned ? 32'(h) : 32'(signed'(h));
                    else
                        exp_d = {mm[sel][a+3], mm[sel][a+2], mm[sel][a+1], mm[sel][a]};
                end
            end
        end
    end

    task automatic xact(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] want_d, input logic want_e, input int hold);
        logic ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_req_ready) begin ok = 1'b1; break; end
        end
        chk1({name, "_accepted"}, ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_rsp_valid) begin ok = 1'b1; break; end
        end
        chk1({name, "_responded"}, ok, 1'b1);
        repeat (hold) @(negedge clk);
        if (hold > 0) chk1({name, "_req_ready_held_low"}, d_req_ready, 1'b0);
        chk32({name, "_rdata"}, d_rsp_rdata, want_d);
        chk1({name, "_err"}, d_rsp_err, want_e);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk1({name, "_idle_after_handshake"}, d_req_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk1({name, "_req_ready"}, d_req_ready, 1'b1);
        chk1({name, "_rsp_valid"}, d_rsp_valid, 1'b0);
        chk32({name, "_rsp_rdata"}, d_rsp_rdata, 32'h0);
        chk1({name, "_rsp_err"}, d_rsp_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; sel = 0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst = 1'b1;

        // LATENCY=2 instance
        xact("st_word",   1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 0);
        xact("ld_word",   1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 0);
        xact("ld_b13_s",  1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0, 0);
        xact("ld_b13_u",  1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 32'h000000DE, 1'b0, 0);
        xact("ld_h10_s",  1'b0, 32'h10, 32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 1'b0, 0);
        xact("ld_h12_u",  1'b0, 32'h12, 32'h0,        2'd1, 1'b1, 32'h0000DEAD, 1'b0, 0);
        xact("st_b11",    1'b1, 32'h11, 32'h00000055, 2'd0, 1'b0, 32'h0,        1'b0, 0);
        xact("ld_after_b",1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0, 0);
        xact("err_ld_w12",1'b0, 32'h12, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 0);
        xact("err_st_h401",1'b1,32'h401,32'hFFFFFFFF, 2'd1, 1'b0, 32'h0,        1'b1, 0);
        xact("err_ld_sz3",1'b0, 32'h10, 32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 0);
        xact("err_st_sz3",1'b1, 32'h10, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h0,        1'b1, 0);
        xact("err_ld_oor",1'b0, 32'h400,32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 0);
        xact("ld_unchgd", 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0, 0);
        xact("backpress", 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0, 5);

        // Reset while waiting: the store to 0x20 must never land.
        xact("st_pre20",  1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 1'b0, 32'h0,        1'b0, 0);
        xact("ld_pre20",  1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 32'hA5A5A5A5, 1'b0, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
        @(negedge clk);
        chk1("rst_wait_ready_before_accept", d_req_ready, 1'b1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        #1 chk_reset_outputs("rst_in_wait");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        xact("ld_post20", 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 32'hA5A5A5A5, 1'b0, 0);

        // LATENCY=0 instance
        sel = 1;
        xact("l0_st_word",1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 0);
        xact("l0_ld_word",1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 0);
        xact("l0_ld_b13", 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0, 0);
        xact("l0_bp",     1'b0, 32'h10, 32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0, 3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
